// File: rtl/des_round_controller_if.sv
// des_round_controller_if: host block handshake between a DES host and the round engine
interface des_round_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  modport master (output in_valid, in_data, in_key, in_decrypt, out_ready,
                  input in_ready, out_valid, out_data, busy);
  modport slave (input in_valid, in_data, in_key, in_decrypt, out_ready,
                 output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/des_round_controller.sv
// des_round_controller: iterative DES engine, one Feistel round per clock with on-the-fly key schedule
module des_round_controller #(
  parameter int ROUNDS = 16
) (
  input logic clk,
  input logic rst,
  des_round_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
    26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [2047:0] SBOX = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
    return y;
  endfunction
  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
    return y;
  endfunction
  function automatic logic [27:0] rot_f(input logic [27:0] v, input logic [1:0] n, input logic right);
    return right ? ((v >> n) | (v << (5'd28 - 5'(n)))) : ((v << n) | (v >> (5'd28 - 5'(n))));
  endfunction
  function automatic logic [31:0] feistel_f(input logic [47:0] k, input logic [31:0] r);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_T[i]];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[47 - 6 * j -: 6];
      s[31 - 4 * j -: 4] = SBOX[2047 - 256 * j - 4 * int'({b[5], b[0], b[4:1]}) -: 4];
    end
    for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
    return y;
  endfunction
  state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic dec_q, dec_d;
  logic [63:0] out_q, out_d;
  logic [63:0] ip_w;
  logic [55:0] pc1_w;
  logic one_sh;
  logic [1:0] sh;
  logic [27:0] c_rot, d_rot;
  logic [31:0] f_w;
  assign ip_w = ip_f(bus.in_data);
  assign pc1_w = pc1_f(bus.in_key);
  // decrypt starts from the unrotated key (K16) and walks the schedule backwards
  assign one_sh = rnd_q inside {4'd1, 4'd8, 4'd15};
  assign sh = (rnd_q == 4'd0) ? {1'b0, ~dec_q} : one_sh ? 2'd1 : 2'd2;
  assign c_rot = rot_f(c_q, sh, dec_q);
  assign d_rot = rot_f(d_q, sh, dec_q);
  assign f_w = feistel_f(pc2_f({c_rot, d_rot}), r_q);
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = (state_q == ROUND) || (state_q == DONE);
  assign bus.out_data = out_q;
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    l_d = l_q;
    r_d = r_q;
    c_d = c_q;
    d_d = d_q;
    dec_d = dec_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        {l_d, r_d} = ip_w;
        {c_d, d_d} = pc1_w;
        dec_d = bus.in_decrypt;
        rnd_d = 4'd0;
        state_d = ROUND;
      end
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_w;
        c_d = c_rot;
        d_d = d_rot;
        rnd_d = (rnd_q == LAST) ? rnd_q : rnd_q + 4'd1;
        state_d = (rnd_q == LAST) ? DONE : ROUND;
        out_d = (rnd_q == LAST) ? fp_f({l_q ^ f_w, r_q}) : out_q;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q <= 4'd0;
      l_q <= 32'd0;
      r_q <= 32'd0;
      c_q <= 28'd0;
      d_q <= 28'd0;
      dec_q <= 1'b0;
      out_q <= 64'd0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      l_q <= l_d;
      r_q <= r_d;
      c_q <= c_d;
      d_q <= d_d;
      dec_q <= dec_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_des_round_controller.sv
// tb_des_round_controller: directed and random DES transactions checked against a behavioural DES model
module tb_des_round_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  des_round_controller_if bus();
  des_round_controller #(.ROUNDS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10, 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  // IP row r holds source positions 58+2r-8c (r<4) or 49+2r-8c; FP is its inverse
  function automatic int ip_src(input int p);
    return ((p / 8 < 4) ? 58 + 2 * (p / 8) : 49 + 2 * (p / 8)) - 8 * (p % 8);
  endfunction
  function automatic logic [63:0] ip_m(input logic [63:0] x);
    logic [63:0] y;
    for (int p = 0; p < 64; p++) y[63 - p] = x[64 - ip_src(p)];
    return y;
  endfunction
  function automatic logic [63:0] fp_m(input logic [63:0] x);
    logic [63:0] y;
    for (int p = 0; p < 64; p++) y[64 - ip_src(p)] = x[63 - p];
    return y;
  endfunction
  function automatic logic [31:0] f_m(input logic [47:0] k, input logic [31:0] r);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) x[47 - i] = r[32 - (((i / 6) * 4 + i % 6 + 31) % 32 + 1)];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[47 - 6 * j -: 6];
      s[31 - 4 * j -: 4] = 4'(SB[j][32 * int'(b[5]) + 16 * int'(b[0]) + int'(b[4:1])]);
    end
    for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] des_m(input logic [63:0] key, input logic [63:0] data, input logic dec);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] ks [16];
    logic [63:0] lr;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    {c, d} = cd;
    for (int i = 0; i < 16; i++) begin
      repeat (SHIFTS[i]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      for (int j = 0; j < 48; j++) ks[i][47 - j] = {c, d}[56 - PC2_T[j]];
    end
    lr = ip_m(data);
    {l, r} = lr;
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_m(ks[dec ? 15 - i : i], r);
      l = t;
    end
    return fp_m({r, l});
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [63:0] key, input logic [63:0] data, input logic dec);
    bus.in_valid = 1'b1;
    bus.in_key = key;
    bus.in_data = data;
    bus.in_decrypt = dec;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic xfer(input logic [63:0] key, input logic [63:0] data, input logic dec, input int hold,
                      output logic [63:0] res, output int lat);
    start(key, data, dec);
    chk("busy_after_accept", {62'd0, bus.busy, bus.in_ready}, 64'd2);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.out_data;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  logic [63:0] res;
  logic [63:0] k;
  logic [63:0] dt;
  logic [63:0] d2;
  logic dc;
  int lat;
  int hold;
  int cyc;
  int a1;
  int a2;
  int seen;
  logic [63:0] outs [$];
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_key = 64'd0;
    bus.in_data = 64'd0;
    bus.in_decrypt = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
    chk("reset_data", bus.out_data, 64'd0);
    rst = 1'b0;
    xfer(K1, D1, 1'b0, 0, res, lat);
    chk("t1_enc", res, C1);
    chk("t1_model", res, des_m(K1, D1, 1'b0));
    chk("t1_latency", 64'(lat), 64'd17);
    xfer(K1, C1, 1'b1, 1, res, lat);
    chk("t2_dec", res, D1);
    xfer(64'd0, 64'd0, 1'b0, 0, res, lat);
    chk("t3_zero", res, 64'h8CA64DE9C1B123A7);
    xfer(64'h123556789ABDDEF0, D1, 1'b0, 2, res, lat);
    chk("t3_parity", res, C1);
    start(K1, D1, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b1;
    bus.in_data = 64'hFFFF0000FFFF0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_data", bus.out_data, C1);
      chk("t4_hold_flags", {bus.in_ready, bus.out_valid, bus.busy}, 64'd3);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("t4_release", {bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
    start(K1, D1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_reset_flags", {bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
    chk("t5_reset_data", bus.out_data, 64'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen += int'(bus.out_valid);
    end
    chk("t5_no_pulse", 64'(seen), 64'd0);
    xfer(K1, D1, 1'b0, 0, res, lat);
    chk("t5_rerun", res, C1);
    chk("t5_latency", 64'(lat), 64'd17);
    d2 = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    bus.in_key = K1;
    bus.in_data = D1;
    bus.in_decrypt = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    a1 = -1;
    a2 = -1;
    while (outs.size() < 2 && cyc < 80) begin
      dc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (dc && a1 < 0) begin
        a1 = cyc;
        bus.in_data = d2;
      end else if (dc) begin
        a2 = cyc;
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) outs.push_back(bus.out_data);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("t6_spacing", 64'(a2 - a1), 64'd18);
    chk("t6_first", outs.size() > 0 ? outs[0] : 64'hx, C1);
    chk("t6_second", outs.size() > 1 ? outs[1] : 64'hx, des_m(K1, d2, 1'b0));
    for (int i = 0; i < 12; i++) begin
      k = {$urandom, $urandom};
      dt = {$urandom, $urandom};
      dc = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      xfer(k, dt, dc, hold, res, lat);
      chk("rand_result", res, des_m(k, dt, dc));
      chk("rand_latency", 64'(lat), 64'd17);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
